snn_gate_net: RTL and testbench

- Parametrised two-layer spiking logic network: N_IN leaky integrate-and-fire hidden neurons, each driven by its own pos/neg spike pair, feeding one output neuron.
- The output neuron sums hidden spikes by count, not by OR. A 2-of-2 AND, an OR, or any k-of-N function is selected by the output threshold alone.
- Adds leak, refractory period, potential saturation and per-neuron disable on top of the basic weight/threshold neuron.
- Sits between spike encoders and the classifier/readout logic.

---
 rtl/snn_gate_net.sv | 199 +++++++++++++++++++
 tb/tb_snn_gate_net.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/snn_gate_net.sv
// snn_gate_net: two-layer leaky integrate-and-fire spiking gate network.
// N_IN hidden neurons, each driven by its own pos/neg spike pair, feed one
// output neuron. The output neuron integrates the signed count of hidden
// spikes, so its threshold alone selects AND / OR / k-of-N behaviour.
module snn_gate_net #(
    parameter int N_IN        = 2,
    parameter int TW          = 8,
    parameter int PW          = 10,
    parameter int LEAK_PERIOD = 16,
    parameter int REFRAC      = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_IN-1:0]      w_hid,
    input  logic [N_IN*TW-1:0]   th_hid,
    input  logic                 w_out,
    input  logic [TW-1:0]        th_out,
    input  logic [N_IN-1:0]      pos_in,
    input  logic [N_IN-1:0]      neg_in,
    output logic [N_IN-1:0]      hid_pos,
    output logic [N_IN-1:0]      hid_neg,
    output logic                 pos_out,
    output logic                 neg_out
);

    // Signed width of the output neuron's popcount difference.
    localparam int OW  = $clog2(N_IN + 1) + 1;
    localparam int LCW = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
    localparam int RCW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

    localparam logic [LCW-1:0] LEAK_LAST = LCW'((LEAK_PERIOD > 0) ? LEAK_PERIOD - 1 : 0);
    localparam logic [RCW-1:0] REF_LOAD  = RCW'(REFRAC);
    localparam logic signed [PW-1:0] V_MAX = {1'b0, {(PW-1){1'b1}}};
    localparam logic signed [PW-1:0] V_MIN = {1'b1, {(PW-1){1'b0}}};
    localparam logic signed [PW-1:0] V_ONE = {{(PW-1){1'b0}}, 1'b1};

    // Add with clamping to the PW range instead of wrapping.
    function automatic logic signed [PW-1:0] sat_add(
        input logic signed [PW-1:0] a,
        input logic signed [PW-1:0] b
    );
        logic signed [PW:0] s;
        s = {a[PW-1], a} + {b[PW-1], b};
        if (s[PW] != s[PW-1]) begin
            return s[PW] ? V_MIN : V_MAX;
        end
        return s[PW-1:0];
    endfunction

    // One leak step toward zero; zero stays zero.
    function automatic logic signed [PW-1:0] leak_step(input logic signed [PW-1:0] v);
        if (v > 0) begin
            return v - V_ONE;
        end else if (v < 0) begin
            return v + V_ONE;
        end
        return v;
    endfunction

    // Shared neuron update: refractory gating, leak, saturation, fire/reset.
    function automatic void neuron_step(
        input  logic signed [PW-1:0] v,
        input  logic [RCW-1:0]       rc,
        input  logic signed [PW-1:0] raw,
        input  logic                 w,
        input  logic [TW-1:0]        th,
        input  logic                 tick,
        output logic signed [PW-1:0] v_n,
        output logic [RCW-1:0]       rc_n,
        output logic                 fire_p,
        output logic                 fire_n
    );
        logic signed [PW-1:0] d;
        logic signed [PW-1:0] vn;
        logic signed [PW-1:0] th_s;
        d      = w ? raw : -raw;
        rc_n   = rc;
        fire_p = 1'b0;
        fire_n = 1'b0;
        if (rc != '0) begin
            d    = '0;
            rc_n = rc - 1'b1;
        end
        vn = sat_add(v, d);
        if (tick && (d == '0)) begin
            vn = leak_step(vn);
        end
        // Threshold is unsigned; PW >= TW+2 keeps +th and -th representable.
        th_s = {{(PW-TW){1'b0}}, th};
        v_n  = vn;
        if ((th != '0) && (rc == '0)) begin
            if (vn >= th_s) begin
                fire_p = 1'b1;
                v_n    = '0;
                rc_n   = REF_LOAD;
            end else if (vn <= -th_s) begin
                fire_n = 1'b1;
                v_n    = '0;
                rc_n   = REF_LOAD;
            end
        end
    endfunction

    logic [LCW-1:0]       leak_cnt_q, leak_cnt_d;
    logic                 leak_tick;
    logic signed [PW-1:0] v_hid_q [N_IN];
    logic signed [PW-1:0] v_hid_d [N_IN];
    logic [RCW-1:0]       rc_hid_q [N_IN];
    logic [RCW-1:0]       rc_hid_d [N_IN];
    logic [N_IN-1:0]      hid_pos_q, hid_pos_d;
    logic [N_IN-1:0]      hid_neg_q, hid_neg_d;
    logic signed [PW-1:0] v_out_q, v_out_d;
    logic [RCW-1:0]       rc_out_q, rc_out_d;
    logic                 pos_out_q, pos_out_d;
    logic                 neg_out_q, neg_out_d;
    logic [OW-1:0]        cnt_p, cnt_n;
    logic signed [OW-1:0] raw_o;

    // Global free-running leak counter; tick on the last count, then wrap.
    always_comb begin
        leak_cnt_d = leak_cnt_q;
        leak_tick  = 1'b0;
        if (LEAK_PERIOD != 0) begin
            if (leak_cnt_q == LEAK_LAST) begin
                leak_tick  = 1'b1;
                leak_cnt_d = '0;
            end else begin
                leak_cnt_d = leak_cnt_q + 1'b1;
            end
        end
    end

    // Hidden layer: each neuron sees its own pos/neg pair as raw = p - n.
    always_comb begin
        hid_pos_d = '0;
        hid_neg_d = '0;
        for (int i = 0; i < N_IN; i++) begin
            v_hid_d[i]  = v_hid_q[i];
            rc_hid_d[i] = rc_hid_q[i];
            neuron_step(v_hid_q[i], rc_hid_q[i],
                        {{(PW-1){1'b0}}, pos_in[i]} - {{(PW-1){1'b0}}, neg_in[i]},
                        w_hid[i], th_hid[i*TW +: TW], leak_tick,
                        v_hid_d[i], rc_hid_d[i], hid_pos_d[i], hid_neg_d[i]);
        end
    end

    // Output neuron: integrates popcount(hid_pos) - popcount(hid_neg).
    always_comb begin
        cnt_p = '0;
        cnt_n = '0;
        for (int i = 0; i < N_IN; i++) begin
            cnt_p = cnt_p + OW'(hid_pos_q[i]);
            cnt_n = cnt_n + OW'(hid_neg_q[i]);
        end
        raw_o     = cnt_p - cnt_n;
        v_out_d   = v_out_q;
        rc_out_d  = rc_out_q;
        pos_out_d = 1'b0;
        neg_out_d = 1'b0;
        neuron_step(v_out_q, rc_out_q, {{(PW-OW){raw_o[OW-1]}}, raw_o},
                    w_out, th_out, leak_tick,
                    v_out_d, rc_out_d, pos_out_d, neg_out_d);
    end

    // State and spike registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            leak_cnt_q <= '0;
            for (int i = 0; i < N_IN; i++) begin
                v_hid_q[i]  <= '0;
                rc_hid_q[i] <= '0;
            end
            hid_pos_q <= '0;
            hid_neg_q <= '0;
            v_out_q   <= '0;
            rc_out_q  <= '0;
            pos_out_q <= 1'b0;
            neg_out_q <= 1'b0;
        end else begin
            leak_cnt_q <= leak_cnt_d;
            for (int i = 0; i < N_IN; i++) begin
                v_hid_q[i]  <= v_hid_d[i];
                rc_hid_q[i] <= rc_hid_d[i];
            end
            hid_pos_q <= hid_pos_d;
            hid_neg_q <= hid_neg_d;
            v_out_q   <= v_out_d;
            rc_out_q  <= rc_out_d;
            pos_out_q <= pos_out_d;
            neg_out_q <= neg_out_d;
        end
    end

    assign hid_pos = hid_pos_q;
    assign hid_neg = hid_neg_q;
    assign pos_out = pos_out_q;
    assign neg_out = neg_out_q;

endmodule

// File: tb/tb_snn_gate_net.sv
// Directed bench for snn_gate_net: three instances share stimulus and differ
// only in leak/refractory parameters; each phase checks the relevant one.
module tb_snn_gate_net;

    localparam int N  = 2;
    localparam int TW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    w_hid;
    logic [N*TW-1:0] th_hid;
    logic            w_out;
    logic [TW-1:0]   th_out;
    logic [N-1:0]    pos_in;
    logic [N-1:0]    neg_in;

    logic [N-1:0] a_hp, a_hn, l_hp, l_hn, r_hp, r_hn;
    logic         a_po, a_no, l_po, l_no, r_po, r_no;

    int checks = 0;
    int errors = 0;
    int fires;

    snn_gate_net #(.N_IN(N), .TW(TW), .PW(10), .LEAK_PERIOD(0), .REFRAC(0)) u_a (
        .clk(clk), .rst(rst), .w_hid(w_hid), .th_hid(th_hid), .w_out(w_out),
        .th_out(th_out), .pos_in(pos_in), .neg_in(neg_in),
        .hid_pos(a_hp), .hid_neg(a_hn), .pos_out(a_po), .neg_out(a_no));

    snn_gate_net #(.N_IN(N), .TW(TW), .PW(10), .LEAK_PERIOD(4), .REFRAC(0)) u_l (
        .clk(clk), .rst(rst), .w_hid(w_hid), .th_hid(th_hid), .w_out(w_out),
        .th_out(th_out), .pos_in(pos_in), .neg_in(neg_in),
        .hid_pos(l_hp), .hid_neg(l_hn), .pos_out(l_po), .neg_out(l_no));

    snn_gate_net #(.N_IN(N), .TW(TW), .PW(10), .LEAK_PERIOD(0), .REFRAC(3)) u_r (
        .clk(clk), .rst(rst), .w_hid(w_hid), .th_hid(th_hid), .w_out(w_out),
        .th_out(th_out), .pos_in(pos_in), .neg_in(neg_in),
        .hid_pos(r_hp), .hid_neg(r_hn), .pos_out(r_po), .neg_out(r_no));

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        pos_in = '0;
        neg_in = '0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        rst    = 1'b1;
        w_hid  = 2'b11;
        th_hid = {8'd1, 8'd1};
        w_out  = 1'b1;
        th_out = 8'd2;
        pos_in = '0;
        neg_in = '0;
        repeat (2) step();
        check_eq("rst_hid", {a_hp, a_hn, r_hp, r_hn}, 32'h0);
        check_eq("rst_out", {a_po, a_no, r_po, r_no}, 32'h0);
        rst = 1'b0;

        // AND: both channels together fire the 2-of-2 output.
        pos_in = 2'b11;
        step();
        check_eq("and_hid", a_hp, 2'b11);
        check_eq("and_out_early", a_po, 1'b0);
        pos_in = 2'b00;
        step();
        check_eq("and_out", a_po, 1'b1);
        check_eq("and_hid_clr", a_hp, 2'b00);
        step();
        check_eq("and_out_1cyc", a_po, 1'b0);
        // A single channel only half-charges the output neuron.
        pos_in = 2'b01;
        step();
        check_eq("and_single_hid", a_hp, 2'b01);
        pos_in = 2'b00;
        step();
        check_eq("and_single_out", a_po, 1'b0);
        repeat (3) step();
        pos_in = 2'b01;
        step();
        pos_in = 2'b00;
        step();
        check_eq("and_accum_out", a_po, 1'b1);

        // OR / invert: ch1 inverted turns a neg spike into a pos spike.
        do_reset();
        th_out = 8'd1;
        w_hid  = 2'b01;
        neg_in = 2'b10;
        step();
        check_eq("or_hid_pos", a_hp, 2'b10);
        check_eq("or_hid_neg", a_hn, 2'b00);
        neg_in = 2'b00;
        step();
        check_eq("or_pos_out", {a_po, a_no}, 2'b10);
        w_out  = 1'b0;
        neg_in = 2'b10;
        step();
        neg_in = 2'b00;
        step();
        check_eq("inv_neg_out", {a_po, a_no}, 2'b01);
        w_out = 1'b1;

        // Refractory: held input fires on cycles 1 and 5 only (REFRAC=3).
        do_reset();
        w_hid  = 2'b11;
        th_hid = {8'd1, 8'd1};
        th_out = 8'd0;
        pos_in = 2'b01;
        for (int i = 0; i < 8; i++) begin
            step();
            check_eq($sformatf("refrac_c%0d", i + 1), r_hp[0], (i == 0 || i == 4) ? 1'b1 : 1'b0);
        end
        check_eq("norefrac_every", a_hp[0], 1'b1);
        pos_in = 2'b00;

        // Leak: 3 pulses decay to 0 in 16 idle cycles, so the 4th does not fire.
        do_reset();
        th_hid = {8'd4, 8'd4};
        pos_in = 2'b01;
        repeat (3) step();
        check_eq("leak_charge", l_hp, 2'b00);
        pos_in = 2'b00;
        repeat (16) step();
        pos_in = 2'b01;
        step();
        check_eq("leak_4th_nofire", l_hp[0], 1'b0);
        step();
        step();
        check_eq("leak_6th_nofire", l_hp[0], 1'b0);
        step();
        check_eq("leak_refire", l_hp[0], 1'b1);
        // Partial decay: 3 -> 2 over 4 idle cycles, then two pulses reach 4.
        repeat (3) step();
        pos_in = 2'b00;
        repeat (4) step();
        pos_in = 2'b01;
        step();
        check_eq("leak_part_nofire", l_hp[0], 1'b0);
        step();
        check_eq("leak_part_fire", l_hp[0], 1'b1);
        pos_in = 2'b00;

        // Disabled neuron saturates at +511 without firing or wrapping.
        do_reset();
        th_hid = {8'd1, 8'd0};
        pos_in = 2'b01;
        fires  = 0;
        repeat (600) begin
            step();
            if (a_hp[0] || a_hn[0]) fires++;
        end
        check_eq("sat_nofire", fires, 0);
        th_hid = {8'd1, 8'd200};
        pos_in = 2'b00;
        step();
        check_eq("sat_enable_fire", {a_hp[0], a_hn[0]}, 2'b10);

        // Async reset mid-refractory clears outputs without a clock edge.
        do_reset();
        th_hid = {8'd1, 8'd1};
        pos_in = 2'b01;
        step();
        check_eq("arst_pre", r_hp[0], 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_imm", {r_hp, r_hn, r_po, r_no}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check_eq("arst_first_edge", r_hp[0], 1'b1);
        pos_in = 2'b00;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
